msrv32_fetch_seq: RTL and testbench
===================================

Name: msrv32_fetch_seq

Overview:
- Fetch sequencer that drives the PC-mux source select and owns the architectural PC register.
- Decides each cycle whether the next fetch address is:
  - boot,
  - exception return (epc),
  - trap vector,
  - sequential/branch next-PC.
- Holds the PC during AHB wait states and buffers redirect requests that arrive while the bus is stalled.
- Sits between the machine-control/CSR unit (trap/mret requests) and the PC mux / instruction AHB port.

Parameters:
- BOOT_ADDRESS, 32'h0000_0000, PC value loaded on reset; must match the PC mux boot constant.
- STALL_TIMEOUT, 16, consecutive not-ready cycles before bus_timeout_out asserts (range 2..255).

Ports:
- ms_riscv32_mp_clk_in  input  1  core clock, rising edge.
- ms_riscv32_mp_rst_in  input  1  asynchronous, active-high reset.
- ahb_ready_in  input  1  instruction bus ready; fetch address accepted on a ready cycle.
- trap_req_in  input  1  exception/interrupt taken (one-cycle pulse from machine control).
- mret_req_in  input  1  MRET retiring (one-cycle pulse).
- misaligned_instr_in  input  1  misaligned branch target flag from the PC mux.
- pc_mux_in  input  32  selected next address from the PC mux.
- pc_src_out  output  2  PC-mux select: 00 boot, 01 epc, 10 trap, 11 next-PC.
- pc_out  output  32  registered current PC (fed back to the PC mux pc input).
- fetch_valid_out  output  1  the instruction at pc_out is valid for decode.
- flush_out  output  1  kill the in-flight instruction (redirect accepted).
- misaligned_trap_out  output  1  one-cycle pulse: misaligned target converted to a trap redirect.
- redirect_pending_out  output  1  a trap/mret redirect is buffered awaiting ahb_ready_in.
- bus_timeout_out  output  1  stall count reached STALL_TIMEOUT.

Behaviour:
- Reset (asynchronous, any time, including mid-stall or with a request pending). All state clears immediately:
  - state=BOOT, pc_out=BOOT_ADDRESS, pc_src_out=00,
  - fetch_valid_out=0, flush_out=1,
  - misaligned_trap_out=0, redirect_pending_out=0, bus_timeout_out=0,
  - pending register cleared, stall counter=0.
- State BOOT:
  - pc_src_out=00.
  - On the first edge with ahb_ready_in=1: pc_out<=pc_mux_in, go to RUN, fetch_valid_out<=1, flush_out<=0.
  - Otherwise stay in BOOT.
- State RUN, select priority:
  - pending-trap or trap_req_in -> 10,
  - else pending-mret or mret_req_in -> 01,
  - else misaligned_instr_in -> 10,
  - else 11.
  - pc_src_out is combinational from state, the pending register and the request inputs.
- Edge with ahb_ready_in=1:
  - pc_out<=pc_mux_in.
  - If the select was 10 or 01 (a redirect): flush_out<=1 and fetch_valid_out<=0 for exactly one cycle, then the pending register clears.
  - If the redirect came from misaligned_instr_in: misaligned_trap_out pulses for the same cycle as flush_out.
  - Otherwise fetch_valid_out<=1, flush_out<=0.
- Edge with ahb_ready_in=0:
  - pc_out holds; fetch_valid_out<=0.
  - trap_req_in / mret_req_in are latched into the 2-bit pending register. Trap overwrites mret; mret never overwrites trap.
  - redirect_pending_out=1 while the pending register is non-empty.
- Simultaneous trap_req_in and mret_req_in: trap wins; the mret is dropped.
- Request arriving on the same edge that consumes a pending request:
  - the new request is accepted next cycle (it is not lost),
  - this holds only if it is a trap or the pending one was a trap.
- Stall counter (8-bit):
  - increments on each ahb_ready_in=0 edge, saturating at STALL_TIMEOUT,
  - clears on any ahb_ready_in=1 edge.
- bus_timeout_out=1 while counter==STALL_TIMEOUT. It is a level and drops on the edge ready returns; no state change is caused by a timeout.
- misaligned_instr_in is sampled only when ahb_ready_in=1 and no trap/mret is selected. It is never buffered.
- Latency:
  - redirect request to pc_out update: 1 cycle with the bus ready,
  - otherwise 1 cycle after ahb_ready_in returns.

Test Plan:
- Reset release, ahb_ready_in=1, pc_mux_in=0x0 -> cycle 0: pc_src_out=00, flush_out=1. Next edge: pc_out=0x0, state RUN, pc_src_out=11, fetch_valid_out=1.
- RUN, pc_mux_in tracks pc_out+4 for 4 cycles -> pc_out=0x4,0x8,0xC,0x10; flush_out stays 0.
- trap_req_in pulse while ahb_ready_in=0 for 3 cycles, with trap vector 0x100 on pc_mux_in when select=10:
  - redirect_pending_out=1 and pc_src_out=10 throughout,
  - on the ready edge pc_out=0x100, flush_out=1 for one cycle, then pending clears.
- trap_req_in and mret_req_in in the same cycle, with epc 0x200 and vector 0x100 -> pc_src_out=10, pc_out=0x100, no later 01 select.
- misaligned_instr_in=1 with branch taken -> pc_src_out=10, misaligned_trap_out and flush_out pulse one cycle, pc_out=trap vector.
- ahb_ready_in=0 for 20 cycles, STALL_TIMEOUT=16 -> bus_timeout_out rises after the 16th low edge and clears when ready returns. Assert reset mid-stall -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/msrv32_fetch_seq.sv
// Fetch sequencer: owns the architectural PC, drives the PC-mux select and
// buffers trap/mret redirects that arrive while the instruction bus is stalled.
module msrv32_fetch_seq #(
  parameter logic [31:0] BOOT_ADDRESS  = 32'h0000_0000,
  parameter int          STALL_TIMEOUT = 16
) (
  input  logic        ms_riscv32_mp_clk_in,
  input  logic        ms_riscv32_mp_rst_in,
  input  logic        ahb_ready_in,
  input  logic        trap_req_in,
  input  logic        mret_req_in,
  input  logic        misaligned_instr_in,
  input  logic [31:0] pc_mux_in,
  output logic [1:0]  pc_src_out,
  output logic [31:0] pc_out,
  output logic        fetch_valid_out,
  output logic        flush_out,
  output logic        misaligned_trap_out,
  output logic        redirect_pending_out,
  output logic        bus_timeout_out
);

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [1:0] SRC_BOOT = 2'b00;
  localparam logic [1:0] SRC_EPC  = 2'b01;
  localparam logic [1:0] SRC_TRAP = 2'b10;
  localparam logic [1:0] SRC_NEXT = 2'b11;
  localparam logic [7:0] TIMEOUT_C = 8'(STALL_TIMEOUT);

  state_t      state_q;
  logic [31:0] pc_q;
  logic        valid_q, flush_q, mis_q;
  logic [1:0]  pend_q, pend_d;   // [1] trap buffered, [0] mret buffered
  logic [7:0]  cnt_q, cnt_d;

  logic        trap_sel, mret_sel, mis_redirect, redirect;
  logic [1:0]  src;

  assign trap_sel     = pend_q[1] | trap_req_in;
  assign mret_sel     = pend_q[0] | mret_req_in;
  assign mis_redirect = (state_q == RUN) & ~trap_sel & ~mret_sel & misaligned_instr_in;

  always_comb begin
    src = SRC_NEXT;
    if (state_q == BOOT)          src = SRC_BOOT;
    else if (trap_sel)            src = SRC_TRAP;
    else if (mret_sel)            src = SRC_EPC;
    else if (misaligned_instr_in) src = SRC_TRAP;
  end

  assign redirect = (state_q == RUN) & ((src == SRC_TRAP) | (src == SRC_EPC));

  // A trap always claims the buffer; an mret only fills an empty or mret slot.
  // On the consuming edge, a fresh request survives when it is a trap or
  // when the request being consumed was a trap.
  always_comb begin
    pend_d = pend_q;
    if (state_q == RUN) begin
      if (ahb_ready_in) begin
        pend_d = 2'b00;
        if (pend_q != 2'b00) begin
          if (trap_req_in)                  pend_d = 2'b10;
          else if (mret_req_in && pend_q[1]) pend_d = 2'b01;
        end
      end else begin
        if (trap_req_in)                    pend_d = 2'b10;
        else if (mret_req_in && !pend_q[1]) pend_d = 2'b01;
      end
    end
  end

  always_comb begin
    if (ahb_ready_in)             cnt_d = 8'd0;
    else if (cnt_q == TIMEOUT_C)  cnt_d = cnt_q;
    else                          cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge ms_riscv32_mp_clk_in or posedge ms_riscv32_mp_rst_in) begin
    if (ms_riscv32_mp_rst_in) begin
      state_q <= BOOT;
      pc_q    <= BOOT_ADDRESS;
      valid_q <= 1'b0;
      flush_q <= 1'b1;
      mis_q   <= 1'b0;
      pend_q  <= 2'b00;
      cnt_q   <= 8'd0;
    end else begin
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
      case (state_q)
        BOOT: begin
          if (ahb_ready_in) begin
            state_q <= RUN;
            pc_q    <= pc_mux_in;
            valid_q <= 1'b1;
            flush_q <= 1'b0;
          end
        end
        default: begin
          if (ahb_ready_in) begin
            pc_q <= pc_mux_in;
            if (redirect) begin
              valid_q <= 1'b0;
              flush_q <= 1'b1;
              mis_q   <= mis_redirect;
            end else begin
              valid_q <= 1'b1;
              flush_q <= 1'b0;
              mis_q   <= 1'b0;
            end
          end else begin
            valid_q <= 1'b0;
            flush_q <= 1'b0;
            mis_q   <= 1'b0;
          end
        end
      endcase
    end
  end

  assign pc_src_out           = src;
  assign pc_out               = pc_q;
  assign fetch_valid_out      = valid_q;
  assign flush_out            = flush_q;
  assign misaligned_trap_out  = mis_q;
  assign redirect_pending_out = |pend_q;
  assign bus_timeout_out      = (cnt_q == TIMEOUT_C);

endmodule

// File: tb/tb_msrv32_fetch_seq.sv
// Bench for msrv32_fetch_seq: directed scenarios then random traffic, checked
// against a rule-level model of the fetch sequencer.
module tb_msrv32_fetch_seq;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ahb_ready = 1'b1;
  logic        trap = 1'b0, mret = 1'b0, misal = 1'b0;
  logic [31:0] pc_mux = 32'h0;
  logic [1:0]  pc_src_out;
  logic [31:0] pc_out;
  logic        fetch_valid_out, flush_out, misaligned_trap_out;
  logic        redirect_pending_out, bus_timeout_out;

  int total = 0;
  int bad   = 0;

  // Reference model: run flag, PC, buffered request (0 none, 1 mret, 2 trap)
  bit          m_run;
  logic [31:0] m_pc;
  int          m_pend;
  int          m_cnt;
  bit          m_valid, m_flush, m_mis;
  logic [31:0] epc_val, tvec_val, branch_tgt;
  bit          use_branch;

  msrv32_fetch_seq #(.BOOT_ADDRESS(32'h0), .STALL_TIMEOUT(TMO)) dut (
    .ms_riscv32_mp_clk_in (clk),
    .ms_riscv32_mp_rst_in (rst),
    .ahb_ready_in         (ahb_ready),
    .trap_req_in          (trap),
    .mret_req_in          (mret),
    .misaligned_instr_in  (misal),
    .pc_mux_in            (pc_mux),
    .pc_src_out           (pc_src_out),
    .pc_out               (pc_out),
    .fetch_valid_out      (fetch_valid_out),
    .flush_out            (flush_out),
    .misaligned_trap_out  (misaligned_trap_out),
    .redirect_pending_out (redirect_pending_out),
    .bus_timeout_out      (bus_timeout_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_pc = 32'h0; m_pend = 0; m_cnt = 0;
    m_valid = 0; m_flush = 1; m_mis = 0;
  endtask

  function automatic int exp_sel(input bit tr, input bit mr, input bit mis);
    if (!m_run)                  return 0;
    if (m_pend == 2 || tr)       return 2;
    if (m_pend == 1 || mr)       return 1;
    if (mis)                     return 2;
    return 3;
  endfunction

  function automatic logic [31:0] mux_val(input int sel);
    case (sel)
      0:       return 32'h0;
      1:       return epc_val;
      2:       return tvec_val;
      default: return use_branch ? branch_tgt : m_pc + 32'd4;
    endcase
  endfunction

  task automatic model_edge(input bit rdy, input bit tr, input bit mr, input bit mis,
                            input int sel, input logic [31:0] mux);
    int newp;
    if (rdy) m_cnt = 0;
    else     m_cnt = (m_cnt < TMO) ? m_cnt + 1 : TMO;
    if (!m_run) begin
      if (rdy) begin
        m_run = 1; m_pc = mux; m_valid = 1; m_flush = 0;
      end
    end else if (rdy) begin
      m_pc = mux;
      if (sel == 1 || sel == 2) begin
        m_valid = 0; m_flush = 1;
        m_mis = (m_pend == 0) && !tr && !mr && mis;
        newp = 0;
        if (m_pend != 0) begin
          if (tr)                     newp = 2;
          else if (mr && m_pend == 2) newp = 1;
        end
        m_pend = newp;
      end else begin
        m_valid = 1; m_flush = 0; m_mis = 0; m_pend = 0;
      end
    end else begin
      m_valid = 0; m_flush = 0; m_mis = 0;
      if (tr)                      m_pend = 2;
      else if (mr && m_pend != 2)  m_pend = 1;
    end
  endtask

  task automatic check_regs();
    chk("pc", pc_out, m_pc);
    chk("valid", fetch_valid_out, m_valid);
    chk("flush", flush_out, m_flush);
    chk("mis_trap", misaligned_trap_out, m_mis);
    chk("pending", redirect_pending_out, m_pend != 0);
    chk("timeout", bus_timeout_out, m_cnt == TMO);
  endtask

  // One clock: drive at posedge+1, check select before the edge, registers after.
  task automatic step(input bit rdy, input bit tr, input bit mr, input bit mis);
    int sel;
    logic [31:0] mux;
    ahb_ready = rdy; trap = tr; mret = mr; misal = mis;
    sel = exp_sel(tr, mr, mis);
    mux = mux_val(sel);
    pc_mux = mux;
    #1;
    chk("pc_src", pc_src_out, sel);
    chk("pending_pre", redirect_pending_out, m_pend != 0);
    @(posedge clk);
    model_edge(rdy, tr, mr, mis, sel, mux);
    #1;
    check_regs();
  endtask

  initial begin
    model_reset();
    epc_val = 32'h200; tvec_val = 32'h100; branch_tgt = 32'h0; use_branch = 0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_src", pc_src_out, 2'b00);
    check_regs();
    rst = 1'b0;

    // boot fetch and sequential run
    step(1, 0, 0, 0);
    chk("boot_pc", pc_out, 32'h0);
    chk("boot_valid", fetch_valid_out, 1'b1);
    repeat (4) step(1, 0, 0, 0);
    chk("seq_pc", pc_out, 32'h10);

    // trap during a 3-cycle stall
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("stall_pc_hold", pc_out, 32'h10);
    step(1, 0, 0, 0);
    chk("trap_pc", pc_out, 32'h100);
    chk("trap_flush", flush_out, 1'b1);
    step(1, 0, 0, 0);
    chk("trap_flush_drop", flush_out, 1'b0);

    // simultaneous trap+mret, ready and stalled
    step(1, 1, 1, 0);
    chk("both_pc", pc_out, 32'h100);
    step(1, 0, 0, 0);
    step(0, 1, 1, 0);
    step(0, 0, 1, 0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);

    // misaligned branch target
    use_branch = 1; branch_tgt = 32'h0000_0402;
    step(1, 0, 0, 1);
    chk("mis_pc", pc_out, 32'h100);
    chk("mis_pulse", misaligned_trap_out, 1'b1);
    step(1, 0, 0, 0);
    use_branch = 0;

    // new request on the consuming edge
    step(0, 0, 1, 0);
    step(1, 1, 0, 0);
    step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    step(1, 0, 1, 0);
    step(1, 0, 0, 0);
    step(0, 0, 1, 0);
    step(1, 0, 1, 0);
    step(1, 0, 0, 0);

    // long stall: timeout level
    repeat (20) step(0, 0, 0, 0);
    chk("tmo_high", bus_timeout_out, 1'b1);
    step(1, 0, 0, 0);
    chk("tmo_clear", bus_timeout_out, 1'b0);

    // asynchronous reset mid-stall with a request pending
    step(0, 1, 0, 0);
    repeat (4) step(0, 0, 0, 0);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk("arst_src", pc_src_out, 2'b00);
    check_regs();
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      bit r, t, m, s;
      r = ($urandom_range(0, 3) != 0);
      t = ($urandom_range(0, 9) == 0);
      m = ($urandom_range(0, 7) == 0);
      s = ($urandom_range(0, 9) == 0);
      use_branch = ($urandom_range(0, 4) == 0);
      branch_tgt = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 15) == 0) begin
        epc_val  = $urandom & 32'hFFFF_FFFC;
        tvec_val = $urandom & 32'hFFFF_FFFC;
      end
      step(r, t, m, s);
    end
    repeat (18) step(0, 0, 0, 0);
    step(1, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
